// File: rtl/exec_hazard_ctrl_pkg.sv
// hazard_pkg: shared encodings and state type for the execute-stage hazard controller
package hazard_pkg;
   localparam logic [1:0] FWD_NONE   = 2'b00;
   localparam logic [1:0] FWD_W      = 2'b01;
   localparam logic [1:0] FWD_M      = 2'b10;
   localparam logic [1:0] REGSRC_MEM = 2'b01;

   typedef enum logic {RUN, MD_WAIT} state_t;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rd_m, input logic we_m,
                                          input logic [4:0] rd_w, input logic we_w);
      return (we_m && rd_m != 5'd0 && rd_m == src) ? FWD_M :
             (we_w && rd_w != 5'd0 && rd_w == src) ? FWD_W : FWD_NONE;
   endfunction
endpackage

// File: rtl/exec_hazard_ctrl_if.sv
// exec_hazard_ctrl_if: pipeline-side signal bundle of the hazard controller
interface exec_hazard_ctrl_if #(parameter int CNT_W = 16);
   logic [4:0] r1AddrD, r2AddrD;
   logic [4:0] r1AddrE, r2AddrE, rdAddrE;
   logic       regWriteE;
   logic [1:0] regSrcE;
   logic       mdStartE;
   logic [4:0] rdAddrM;
   logic       regWriteM;
   logic [4:0] rdAddrW;
   logic       regWriteW;
   logic       wrongBranchE;
   logic       mdDone;
   logic [1:0] fwdA, fwdB;
   logic       stallF, stallD, stallE;
   logic       flushD, flushE, flushM;
   logic       mdGo, mdError;
   logic [CNT_W-1:0] stallCycles, flushCount;

   modport master (
      output r1AddrD, r2AddrD, r1AddrE, r2AddrE, rdAddrE, regWriteE, regSrcE, mdStartE,
             rdAddrM, regWriteM, rdAddrW, regWriteW, wrongBranchE, mdDone,
      input  fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, mdGo, mdError,
             stallCycles, flushCount
   );

   modport slave (
      input  r1AddrD, r2AddrD, r1AddrE, r2AddrE, rdAddrE, regWriteE, regSrcE, mdStartE,
             rdAddrM, regWriteM, rdAddrW, regWriteW, wrongBranchE, mdDone,
      output fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, mdGo, mdError,
             stallCycles, flushCount
   );
endinterface

// File: rtl/exec_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   // count up on inc, hold at all-ones, clear synchronously
   always_ff @(posedge clk)
      if (clr) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/exec_hazard_ctrl.sv
// exec_hazard_ctrl: forwarding, load-use stall, mispredict flush and MUL/DIV hold control for E
module exec_hazard_ctrl import hazard_pkg::*; #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input logic               clk,
   input logic               rst,
   exec_hazard_ctrl_if.slave hz
);
   localparam int TW = MD_TIMEOUT > 1 ? $clog2(MD_TIMEOUT) : 1;

   state_t state, state_n;
   logic [TW-1:0] tmo;
   logic load_use, md_timeout, run, hold, br, lu, md;

   assign hz.fwdA = fwd_sel(hz.r1AddrE, hz.rdAddrM, hz.regWriteM, hz.rdAddrW, hz.regWriteW);
   assign hz.fwdB = fwd_sel(hz.r2AddrE, hz.rdAddrM, hz.regWriteM, hz.rdAddrW, hz.regWriteW);

   // state register; reset always lands in RUN, abandoning any MUL/DIV wait
   always_ff @(posedge clk)
      if (rst) state <= RUN;
      else state <= state_n;

   // timeout counter idles at zero in RUN so each wait starts counting from zero
   always_ff @(posedge clk)
      if (rst || state == RUN) tmo <= '0;
      else tmo <= tmo + 1'b1;

   // next state: enter MD_WAIT only when start wins priority, leave on done or timeout
   always_comb begin
      load_use   = hz.regWriteE && hz.regSrcE == REGSRC_MEM && hz.rdAddrE != 5'd0 &&
                   (hz.rdAddrE == hz.r1AddrD || hz.rdAddrE == hz.r2AddrD);
      md_timeout = state == MD_WAIT && !hz.mdDone && tmo == TW'(MD_TIMEOUT - 1);
      state_n    = state == RUN ? ((!hz.wrongBranchE && !load_use && hz.mdStartE) ? MD_WAIT : RUN)
                                : ((hz.mdDone || md_timeout) ? RUN : MD_WAIT);
   end

   // control outputs: branch beats load-use beats MUL/DIV start; everything quiet under reset
   always_comb begin
      run        = !rst && state == RUN;
      hold       = !rst && state == MD_WAIT && !hz.mdDone && !md_timeout;
      br         = run && hz.wrongBranchE;
      lu         = run && !hz.wrongBranchE && load_use;
      md         = run && !hz.wrongBranchE && !load_use && hz.mdStartE;
      hz.stallF  = lu || md || hold;
      hz.stallD  = lu || md || hold;
      hz.stallE  = md || hold;
      hz.flushD  = br;
      hz.flushE  = br || lu;
      hz.flushM  = md || hold;
      hz.mdGo    = md;
      hz.mdError = !rst && md_timeout;
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .clr(rst), .inc(hz.stallF), .cnt(hz.stallCycles));
   sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .clr(rst), .inc(br), .cnt(hz.flushCount));
endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// tb_exec_hazard_ctrl: directed scenario checks of the execute-stage hazard controller
module tb_exec_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   exec_hazard_ctrl_if #(.CNT_W(16)) hz();
   exec_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(hz.slave));

   always #5 clk = ~clk;

   // {stallF, stallD, stallE, flushD, flushE, flushM, mdGo, mdError}
   function automatic logic [7:0] ctl();
      return {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM, hz.mdGo, hz.mdError};
   endfunction

   task automatic clear_inputs();
      hz.r1AddrD = 0; hz.r2AddrD = 0; hz.r1AddrE = 0; hz.r2AddrE = 0; hz.rdAddrE = 0;
      hz.regWriteE = 0; hz.regSrcE = 0; hz.mdStartE = 0; hz.rdAddrM = 0; hz.regWriteM = 0;
      hz.rdAddrW = 0; hz.regWriteW = 0; hz.wrongBranchE = 0; hz.mdDone = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic set_load_use();
      hz.regSrcE = 2'b01; hz.regWriteE = 1'b1; hz.rdAddrE = 5'd7; hz.r2AddrD = 5'd7;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 8'h00); end
      checks++;
      if (hz.stallCycles !== 16'd0 || hz.flushCount !== 16'd0) begin
         failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hz.stallCycles, hz.flushCount);
      end
   endtask

   task automatic test_forward();
      do_reset();
      hz.regWriteM = 1; hz.rdAddrM = 5; hz.regWriteW = 1; hz.rdAddrW = 5; hz.r1AddrE = 5; hz.r2AddrE = 6;
      #1;
      checks++;
      if (hz.fwdA !== 2'b10) begin failures++; $display("FAIL fwdA_m got=%b exp=10", hz.fwdA); end
      checks++;
      if (hz.fwdB !== 2'b00) begin failures++; $display("FAIL fwdB_miss got=%b exp=00", hz.fwdB); end
      hz.regWriteM = 0; hz.r2AddrE = 5;
      #1;
      checks++;
      if (hz.fwdA !== 2'b01) begin failures++; $display("FAIL fwdA_w got=%b exp=01", hz.fwdA); end
      checks++;
      if (hz.fwdB !== 2'b01) begin failures++; $display("FAIL fwdB_w got=%b exp=01", hz.fwdB); end
      hz.regWriteM = 1; hz.rdAddrM = 0; hz.rdAddrW = 0; hz.r1AddrE = 0; hz.r2AddrE = 0;
      #1;
      checks++;
      if (hz.fwdA !== 2'b00 || hz.fwdB !== 2'b00) begin
         failures++; $display("FAIL fwd_r0 got=%b/%b exp=00/00", hz.fwdA, hz.fwdB);
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use();
      #1;
      checks++;
      if (ctl() !== 8'b11001000) begin failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl(), 8'b11001000); end
      next_cycle();
      hz.regWriteE = 0;
      #1;
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL lu_clear got=%b exp=%b", ctl(), 8'h00); end
      checks++;
      if (hz.stallCycles !== 16'd1) begin failures++; $display("FAIL lu_stallcnt got=%0d exp=1", hz.stallCycles); end
      clear_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      set_load_use();
      hz.mdStartE = 1;
      hz.wrongBranchE = 1;
      #1;
      checks++;
      if (ctl() !== 8'b00011000) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl(), 8'b00011000); end
      next_cycle();
      clear_inputs();
      #1;
      checks++;
      if (hz.flushCount !== 16'd1 || hz.stallCycles !== 16'd0) begin
         failures++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", hz.flushCount, hz.stallCycles);
      end
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL br_after got=%b exp=%b", ctl(), 8'h00); end
   endtask

   task automatic test_md_done();
      do_reset();
      hz.mdStartE = 1;
      #1;
      checks++;
      if (ctl() !== 8'b11100110) begin failures++; $display("FAIL md_start got=%b exp=%b", ctl(), 8'b11100110); end
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         hz.mdStartE = (i == 1) ? 1'b0 : hz.mdStartE;
         #1;
         checks++;
         if (ctl() !== 8'b11100100) begin failures++; $display("FAIL md_wait%0d got=%b exp=%b", i, ctl(), 8'b11100100); end
      end
      next_cycle();
      hz.mdDone = 1;
      #1;
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL md_done got=%b exp=%b", ctl(), 8'h00); end
      next_cycle();
      hz.mdDone = 0;
      #1;
      checks++;
      if (hz.stallCycles !== 16'd5) begin failures++; $display("FAIL md_stallcnt got=%0d exp=5", hz.stallCycles); end
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL md_run got=%b exp=%b", ctl(), 8'h00); end
   endtask

   task automatic test_md_timeout();
      do_reset();
      hz.mdStartE = 1;
      next_cycle();
      hz.mdStartE = 0;
      for (int i = 1; i <= 7; i++) begin
         #1;
         checks++;
         if (ctl() !== 8'b11100100) begin failures++; $display("FAIL to_wait%0d got=%b exp=%b", i, ctl(), 8'b11100100); end
         next_cycle();
      end
      #1;
      checks++;
      if (ctl() !== 8'b00000001) begin failures++; $display("FAIL to_error got=%b exp=%b", ctl(), 8'b00000001); end
      next_cycle();
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL to_run got=%b exp=%b", ctl(), 8'h00); end
      checks++;
      if (hz.stallCycles !== 16'd8) begin failures++; $display("FAIL to_stallcnt got=%0d exp=8", hz.stallCycles); end
      hz.mdStartE = 1;
      next_cycle();
      hz.mdStartE = 0;
      repeat (7) next_cycle();
      hz.mdDone = 1;
      #1;
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL to_done_edge got=%b exp=%b", ctl(), 8'h00); end
      next_cycle();
      hz.mdDone = 0;
      #1;
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL to_done_run got=%b exp=%b", ctl(), 8'h00); end
   endtask

   task automatic test_reset_md_wait();
      do_reset();
      hz.mdStartE = 1;
      next_cycle();
      hz.mdStartE = 0;
      next_cycle();
      rst = 1'b1;
      #1;
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL rstw_ctl got=%b exp=%b", ctl(), 8'h00); end
      next_cycle();
      checks++;
      if (hz.stallCycles !== 16'd0 || hz.flushCount !== 16'd0) begin
         failures++; $display("FAIL rstw_cnt got=%0d/%0d exp=0/0", hz.stallCycles, hz.flushCount);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ctl() !== 8'h00) begin failures++; $display("FAIL rstw_idle got=%b exp=%b", ctl(), 8'h00); end
      hz.mdStartE = 1;
      #1;
      checks++;
      if (ctl() !== 8'b11100110) begin failures++; $display("FAIL rstw_run got=%b exp=%b", ctl(), 8'b11100110); end
      clear_inputs();
   endtask

   task automatic test_saturate();
      do_reset();
      set_load_use();
      repeat (65539) next_cycle();
      clear_inputs();
      #1;
      checks++;
      if (hz.stallCycles !== 16'hFFFF) begin failures++; $display("FAIL sat_stall got=%h exp=ffff", hz.stallCycles); end
      next_cycle();
      checks++;
      if (hz.stallCycles !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", hz.stallCycles); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_md_done();
      test_md_timeout();
      test_reset_md_wait();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
